// File: rtl/spi_byte_receiver.sv
// SPI byte receiver: reassembles strobed MOSI bits into words, queues them in a small
// valid/ready FIFO and checks that successive words follow an incrementing count.
module spi_byte_receiver #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              clk_spi,
  input  logic              reset,
  input  logic              ss_n,
  input  logic              sdi,
  input  logic              sdi_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_abort,
  input  logic              check_en,
  output logic              seq_err,
  output logic [ERR_W-1:0]  err_count,
  input  logic              clear
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q;
  logic [CW-1:0]      bit_cnt_q;
  logic [DATA_W-1:0]  sr_q;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               armed_q;
  logic [DATA_W-1:0]  exp_q;
  logic               overrun_q, frame_abort_q, seq_err_q;
  logic [ERR_W-1:0]   err_count_q;

  logic               sample, last, pop, full, push, mismatch;
  logic [DATA_W-1:0]  word;

  always_comb begin
    sample   = !ss_n && sdi_en;
    last     = sample && (bit_cnt_q == CW'(DATA_W - 1));
    word     = LSB_FIRST ? {sdi, sr_q[DATA_W-1:1]} : {sr_q[DATA_W-2:0], sdi};
    pop      = (count_q != '0) && rx_ready;
    full     = (count_q == (AW+1)'(FIFO_DEPTH));
    // A pop on the same edge frees a slot for the incoming word.
    push     = last && (!full || pop);
    mismatch = last && armed_q && check_en && (word != exp_q);
  end

  always_ff @(posedge clk_spi or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      sr_q          <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      armed_q       <= 1'b0;
      exp_q         <= '0;
      overrun_q     <= 1'b0;
      frame_abort_q <= 1'b0;
      seq_err_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      frame_abort_q <= 1'b0;
      seq_err_q     <= 1'b0;

      unique case (state_q)
        StIdle: begin
          bit_cnt_q <= '0;
          if (!ss_n) state_q <= StShift;
        end
        StShift: begin
          if (ss_n) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            frame_abort_q <= (bit_cnt_q != '0);
          end
        end
      endcase

      // Sampling overrides the idle hold so a strobe on the ss_n falling edge counts.
      if (sample) begin
        sr_q      <= word;
        bit_cnt_q <= last ? '0 : bit_cnt_q + CW'(1);
      end

      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push) begin
        mem_q[wr_ptr_q] <= word;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);

      if (last && full && !pop) overrun_q <= 1'b1;

      // Dropped words still resync the expected count.
      if (last) begin
        armed_q <= 1'b1;
        exp_q   <= word + DATA_W'(1);
      end
      if (mismatch) begin
        seq_err_q <= 1'b1;
        if (err_count_q != '1) err_count_q <= err_count_q + ERR_W'(1);
      end

      if (clear) begin
        overrun_q   <= 1'b0;
        err_count_q <= '0;
        armed_q     <= 1'b0;
        seq_err_q   <= 1'b0;
      end
    end
  end

  assign rx_data     = mem_q[rd_ptr_q];
  assign rx_valid    = (count_q != '0);
  assign overrun     = overrun_q;
  assign frame_abort = frame_abort_q;
  assign seq_err     = seq_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Directed bench for spi_byte_receiver: queue scoreboard on popped words, pulse counters
// for seq_err/frame_abort, and direct flag checks after each scenario.
module tb_spi_byte_receiver;

  logic        clk_spi = 1'b0;
  logic        reset = 1'b0;
  logic        ss_n = 1'b1;
  logic        sdi = 1'b0;
  logic        sdi_en = 1'b0;
  logic        rx_ready = 1'b0;
  logic        check_en = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, overrun, frame_abort, seq_err;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  int seq_pulses = 0;
  int abort_pulses = 0;
  int p0;
  logic [7:0] sb_q [$];

  spi_byte_receiver #(
    .DATA_W(8), .LSB_FIRST(1'b1), .FIFO_DEPTH(2), .ERR_W(16)
  ) dut (
    .clk_spi(clk_spi), .reset(reset), .ss_n(ss_n), .sdi(sdi), .sdi_en(sdi_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
    .frame_abort(frame_abort), .check_en(check_en), .seq_err(seq_err),
    .err_count(err_count), .clear(clear)
  );

  always #5 clk_spi = ~clk_spi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and pulse monitor, sampled on the inactive edge.
  always @(negedge clk_spi) begin
    if (seq_err === 1'b1) seq_pulses++;
    if (frame_abort === 1'b1) abort_pulses++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        assert (sb_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_word: observed %0h expected none", rx_data);
        end
      end else begin
        check("rx_data", 32'(rx_data), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk_spi);
    #2;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n, input bit pop_on_last);
    for (int i = 0; i < n; i++) begin
      tick();
      sdi    = w[i];
      sdi_en = 1'b1;
      if (pop_on_last && i == n - 1) rx_ready = 1'b1;
    end
    tick();
    sdi_en = 1'b0;
    if (pop_on_last) rx_ready = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit accept);
    if (accept) sb_q.push_back(w);
    send_bits(w, 8, 1'b0);
  endtask

  task automatic drain();
    int n;
    rx_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_done", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    // Single byte, latency and pop.
    rx_ready = 1'b1;
    tick();
    ss_n = 1'b0;
    send_word(8'hA5, 1'b1);
    check("t1_valid", 32'(rx_valid), 32'd1);
    check("t1_data", 32'(rx_data), 32'hA5);
    tick();
    check("t1_popped", 32'(rx_valid), 32'd0);

    // Incrementing stream with wrap.
    check_en = 1'b1;
    pulse_clear();
    p0 = seq_pulses;
    send_word(8'hFE, 1'b1);
    send_word(8'hFF, 1'b1);
    send_word(8'h00, 1'b1);
    send_word(8'h01, 1'b1);
    drain();
    check("t2_seq_pulses", 32'(seq_pulses - p0), 32'd0);
    check("t2_err_count", 32'(err_count), 32'd0);

    // One break in the count, then resync.
    pulse_clear();
    p0 = seq_pulses;
    send_word(8'h10, 1'b1);
    send_word(8'h11, 1'b1);
    send_word(8'h20, 1'b1);
    send_word(8'h21, 1'b1);
    drain();
    check("t3_seq_pulses", 32'(seq_pulses - p0), 32'd1);
    check("t3_err_count", 32'(err_count), 32'd1);

    // Overrun, then completion coinciding with a pop.
    pulse_clear();
    check("t4_clear_err", 32'(err_count), 32'd0);
    rx_ready = 1'b0;
    send_word(8'h01, 1'b1);
    send_word(8'h02, 1'b1);
    send_word(8'h03, 1'b0);
    check("t4_overrun", 32'(overrun), 32'd1);
    tick();
    check("t4_valid", 32'(rx_valid), 32'd1);
    check("t4_head_stable", 32'(rx_data), 32'h01);
    sb_q.push_back(8'h04);
    send_bits(8'h04, 8, 1'b1);
    check("t4_overrun_sticky", 32'(overrun), 32'd1);
    check("t4_head_after_pop", 32'(rx_data), 32'h02);
    check("t4_err_count", 32'(err_count), 32'd0);
    drain();

    // Aborted partial frame, then a clean frame.
    pulse_clear();
    check("t5_overrun_cleared", 32'(overrun), 32'd0);
    rx_ready = 1'b0;
    p0 = abort_pulses;
    send_bits(8'h1F, 5, 1'b0);
    ss_n = 1'b1;
    tick();
    check("t5_abort_high", 32'(frame_abort), 32'd1);
    tick();
    check("t5_abort_low", 32'(frame_abort), 32'd0);
    check("t5_abort_count", 32'(abort_pulses - p0), 32'd1);
    check("t5_no_word", 32'(rx_valid), 32'd0);
    ss_n = 1'b0;
    p0 = seq_pulses;
    send_word(8'h3C, 1'b1);
    drain();
    check("t5_seq_pulses", 32'(seq_pulses - p0), 32'd0);
    p0 = abort_pulses;
    ss_n = 1'b1;
    repeat (3) tick();
    check("t5_clean_rise", 32'(abort_pulses - p0), 32'd0);

    // Reset mid-word with queued words and set flags.
    ss_n = 1'b0;
    rx_ready = 1'b0;
    pulse_clear();
    send_word(8'h40, 1'b1);
    send_word(8'h47, 1'b1);
    send_word(8'h48, 1'b0);
    check("t6_pre_err", 32'(err_count), 32'd1);
    check("t6_pre_overrun", 32'(overrun), 32'd1);
    send_bits(8'hFF, 3, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(rx_valid), 32'd0);
    check("t6_rst_overrun", 32'(overrun), 32'd0);
    check("t6_rst_err", 32'(err_count), 32'd0);
    check("t6_rst_data", 32'(rx_data), 32'd0);
    sb_q.delete();
    tick();
    reset = 1'b1;
    p0 = seq_pulses;
    rx_ready = 1'b1;
    send_word(8'h55, 1'b1);
    drain();
    check("t6_seq_pulses", 32'(seq_pulses - p0), 32'd0);
    check("t6_err_count", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_byte_receiver.md
Name: spi_byte_receiver

Overview:
Downstream stage of the SPI counter master. Samples the serial MOSI stream on strobed bit slots while its frame select is active, and reassembles bytes (LSB first by default). Completed bytes go into a small FIFO with a valid/ready output handshake. The block also checks that successive bytes follow the master's incrementing count and reports overrun, aborted frames and sequence errors.

Parameters:
DATA_W, 8, bits per received word
LSB_FIRST, 1, 1 = first sampled bit is bit 0; 0 = first sampled bit is bit DATA_W-1
FIFO_DEPTH, 2, output FIFO entries (power of 2, >= 2)
ERR_W, 16, width of sequence-error counter

Ports:
clk_spi  in  1  single clock; all state is on its rising edge
reset  in  1  asynchronous, active-low reset
ss_n  in  1  frame select, active-low
sdi  in  1  serial data (master MOSI)
sdi_en  in  1  bit-sample strobe; sdi is sampled only when ss_n=0 and sdi_en=1
rx_data  out  DATA_W  FIFO head word
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts head when rx_valid=1
overrun  out  1  sticky: a completed word was dropped because the FIFO was full
frame_abort  out  1  one-cycle pulse: ss_n rose with a partial word pending
check_en  in  1  enable sequence checking
seq_err  out  1  one-cycle pulse on a sequence mismatch
err_count  out  ERR_W  saturating count of sequence mismatches
clear  in  1  synchronous clear of overrun and err_count; re-arms the checker

Behaviour:
- Reset (async, reset=0) values: rx_data=0, rx_valid=0, overrun=0, frame_abort=0, seq_err=0, err_count=0. Bit counter=0, FIFO empty, checker un-armed. Reset mid-word discards the partial word.
- Bit counter range 0..DATA_W-1, held at 0 while ss_n=1.
- Shift path:
  - LSB_FIRST=1: sr <= {sdi, sr[DATA_W-1:1]}.
  - LSB_FIRST=0: sr <= {sr[DATA_W-2:0], sdi}.
- Word completion: on the edge that samples the DATA_W-th bit, the assembled word (including that bit) is completed and the bit counter returns to 0.
- FIFO write:
  - The completed word is written into the FIFO on the completion edge.
  - If the FIFO was empty, rx_valid=1 and rx_data=word after that edge (latency 1 cycle from the last sample).
- Pop: occurs when rx_valid && rx_ready; the head advances on that edge.
- rx_data holds stable while rx_valid=1 and rx_ready=0.
- FIFO full at completion:
  - Without a simultaneous pop: the word is dropped and overrun is set.
  - With a simultaneous pop: the pop frees a slot first and the word is accepted, with no overrun.
- Push into an empty FIFO with rx_ready=1: the word is not bypassed; it appears the next cycle.
- Frame abort: ss_n=1 while bit counter != 0 means the partial word is discarded, frame_abort pulses for 1 cycle and the counter goes to 0. If ss_n rises with counter=0, no pulse.
- States:
  - IDLE (ss_n=1) -> SHIFT on ss_n=0.
  - SHIFT -> IDLE on ss_n=1 (abort rule above).
  - SHIFT stays in SHIFT across word boundaries.
- Sequence checker:
  - Evaluated on every completed word, including words dropped on overrun.
  - First word after reset or clear: no compare. It arms the checker and sets exp = word+1.
  - Armed: word != exp and check_en=1 gives seq_err pulse and err_count+1, saturating at 2^ERR_W-1.
  - exp <= word+1 mod 2^DATA_W in all cases (resync, no cascading errors). 0xFF is followed by 0x00.
  - check_en=0: no seq_err and no count, but exp still tracks.
- clear=1 (synchronous):
  - Zeroes overrun and err_count and un-arms the checker.
  - Does not flush the FIFO or the shift state.
  - If clear coincides with overrun set or an error increment, clear wins.
- Simultaneous word completion and ss_n rising on the same edge: the sample is invalid because ss_n=1. A completion can only occur with ss_n=0.

Test Plan:
- Reset, ss_n=0, 8 strobed bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), rx_ready=1 -> rx_valid=1 one cycle after the 8th sample, rx_data=0xA5, popped the next edge.
- Stream 0xFE, 0xFF, 0x00, 0x01 with check_en=1 -> four words out in order, seq_err never asserts, err_count=0 (wrap accepted).
- Stream 0x10, 0x11, 0x20, 0x21 -> one seq_err pulse on 0x20, err_count=1, no error on 0x21 (resync).
- rx_ready=0, send 3 words (0x01, 0x02, 0x03) with FIFO_DEPTH=2 -> overrun=1, FIFO holds 0x01 then 0x02. Send 0x04 on the same edge as a pop with rx_ready=1 -> accepted, FIFO holds 0x02 then 0x04.
- 5 bits sampled then ss_n=1 -> frame_abort pulses 1 cycle, no word produced. Next full frame of 0x3C decodes to 0x3C.
- Assert reset mid-word with 2 words queued -> rx_valid=0 and flags=0 immediately. The next frame 0x55 decodes correctly with no seq_err (checker un-armed).
